// File: rtl/digital_clock_dp_pkg.sv
// Shared definitions for the digital clock datapath: alarm FSM encoding, field limits
// and the load range check used by every time and alarm field.
package digital_clock_dp_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StRinging = 2'd2,
      StSnooze  = 2'd3
   } alarm_state_e;

   localparam int unsigned HR_MAX  = 23;
   localparam int unsigned MIN_MAX = 59;
   localparam int unsigned SEC_MAX = 59;

   // Ring and snooze tick counters.
   localparam int unsigned CNT_W = 9;

   function automatic logic in_range(input logic [5:0] val, input int unsigned max_val);
      return {26'd0, val} <= max_val;
   endfunction

endpackage

// File: rtl/digital_clock_counter.sv
// Modulo-(MaxVal+1) counter with range-checked parallel load, count enable and carry-out.
// Carry is asserted only while enabled at MaxVal, so it can enable the next field directly.
module digital_clock_counter
   import digital_clock_dp_pkg::*;
#(
   parameter int unsigned Width  = 6,
   parameter int unsigned MaxVal = 59
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [5:0]       data_in,
   input  logic             en,
   output logic [Width-1:0] value,
   output logic             carry,
   output logic             load_err
);

   logic [Width-1:0] value_q, value_d;
   logic             load_ok;

   assign load_ok  = load && in_range(data_in, MaxVal);
   assign load_err = load && !load_ok;
   assign carry    = en && (value_q == Width'(MaxVal));
   assign value    = value_q;

   always_comb begin
      value_d = value_q;
      if (load_ok) begin
         value_d = data_in[Width-1:0];
      end else if (en) begin
         value_d = carry ? '0 : value_q + Width'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/digital_clock_dp.sv
// Digital clock datapath: hh:mm:ss time counter, alarm registers and alarm FSM.
// Define DIGITAL_CLOCK_SNOOZE_EN to build the SNOOZE state and its tick counter.
module digital_clock_dp
   import digital_clock_dp_pkg::*;
#(
   parameter int unsigned ALARM_RING_SECS = 60,
   parameter int unsigned SNOOZE_SECS     = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] data_in,
   input  logic       ld_hr,
   input  logic       ld_min,
   input  logic       ld_sec,
   input  logic       ld_alarm_hr,
   input  logic       ld_alarm_min,
   input  logic       ld_alarm_sec,
   input  logic       on,
   input  logic       tick,
   input  logic       alarm_stop,
   input  logic       snooze,
   output logic [4:0] hr,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       alarm,
   output logic       armed,
   output logic       load_err
);

   localparam logic [CNT_W-1:0] RingLast = CNT_W'(ALARM_RING_SECS - 1);

   logic             adv, adv_q;
   logic             sec_carry, min_carry, unused_hr_carry;
   logic             hr_err, min_err, sec_err;
   logic [4:0]       a_hr_q;
   logic [5:0]       a_min_q, a_sec_q;
   logic [2:0]       valid_q;
   logic             a_hr_ok, a_min_ok, a_sec_ok, alarm_load_ok, alarm_load_bad;
   logic             time_match;
   logic             load_err_q, alarm_q;
   alarm_state_e     state_q, state_d;
   logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;

   // Any time load, valid or not, swallows the tick of that cycle.
   assign adv = on && tick && !(ld_hr || ld_min || ld_sec);

   digital_clock_counter #(.Width(6), .MaxVal(SEC_MAX)) u_sec (
      .clk      (clk),
      .reset    (reset),
      .load     (ld_sec),
      .data_in  (data_in),
      .en       (adv),
      .value    (sec),
      .carry    (sec_carry),
      .load_err (sec_err)
   );

   digital_clock_counter #(.Width(6), .MaxVal(MIN_MAX)) u_min (
      .clk      (clk),
      .reset    (reset),
      .load     (ld_min),
      .data_in  (data_in),
      .en       (sec_carry),
      .value    (min),
      .carry    (min_carry),
      .load_err (min_err)
   );

   digital_clock_counter #(.Width(5), .MaxVal(HR_MAX)) u_hr (
      .clk      (clk),
      .reset    (reset),
      .load     (ld_hr),
      .data_in  (data_in),
      .en       (min_carry),
      .value    (hr),
      .carry    (unused_hr_carry),
      .load_err (hr_err)
   );

   assign a_hr_ok        = ld_alarm_hr && in_range(data_in, HR_MAX);
   assign a_min_ok       = ld_alarm_min && in_range(data_in, MIN_MAX);
   assign a_sec_ok       = ld_alarm_sec && in_range(data_in, SEC_MAX);
   assign alarm_load_ok  = a_hr_ok || a_min_ok || a_sec_ok;
   assign alarm_load_bad = (ld_alarm_hr && !a_hr_ok) || (ld_alarm_min && !a_min_ok) ||
                           (ld_alarm_sec && !a_sec_ok);

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_hr_q  <= '0;
         a_min_q <= '0;
         a_sec_q <= '0;
         valid_q <= '0;
      end else begin
         if (a_hr_ok) begin
            a_hr_q     <= data_in[4:0];
            valid_q[2] <= 1'b1;
         end
         if (a_min_ok) begin
            a_min_q    <= data_in;
            valid_q[1] <= 1'b1;
         end
         if (a_sec_ok) begin
            a_sec_q    <= data_in;
            valid_q[0] <= 1'b1;
         end
      end
   end

   assign armed      = &valid_q;
   assign time_match = ({hr, min, sec} == {a_hr_q, a_min_q, a_sec_q});

`ifdef DIGITAL_CLOCK_SNOOZE_EN
   localparam logic [CNT_W-1:0] SnoozeLast = CNT_W'(SNOOZE_SECS - 1);
   logic [CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
`else
   logic unused_snooze;
   assign unused_snooze = snooze;
`endif

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
`ifdef DIGITAL_CLOCK_SNOOZE_EN
      snooze_cnt_d = snooze_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (armed) state_d = StArmed;
         end
         StArmed: begin
            // adv_q marks that the current time was produced by a tick, never by a load.
            if (adv_q && time_match) state_d = StRinging;
         end
         StRinging: begin
            if (!on || alarm_load_ok || alarm_stop) begin
               state_d = StArmed;
`ifdef DIGITAL_CLOCK_SNOOZE_EN
            end else if (snooze) begin
               state_d = StSnooze;
`endif
            end else if (tick) begin
               if (ring_cnt_q == RingLast) state_d = StArmed;
               else ring_cnt_d = ring_cnt_q + CNT_W'(1);
            end
         end
`ifdef DIGITAL_CLOCK_SNOOZE_EN
         StSnooze: begin
            if (!on || alarm_load_ok || alarm_stop) begin
               state_d = StArmed;
            end else if (tick) begin
               if (snooze_cnt_q == SnoozeLast) state_d = StRinging;
               else snooze_cnt_d = snooze_cnt_q + CNT_W'(1);
            end
         end
`endif
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) begin
         ring_cnt_d = '0;
`ifdef DIGITAL_CLOCK_SNOOZE_EN
         snooze_cnt_d = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         ring_cnt_q <= '0;
         alarm_q    <= 1'b0;
         adv_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         alarm_q    <= (state_d == StRinging);
         adv_q      <= adv;
         load_err_q <= hr_err || min_err || sec_err || alarm_load_bad;
      end
   end

`ifdef DIGITAL_CLOCK_SNOOZE_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         snooze_cnt_q <= '0;
      end else begin
         snooze_cnt_q <= snooze_cnt_d;
      end
   end
`endif

   assign alarm    = alarm_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_digital_clock_dp.sv
// Scoreboard bench for digital_clock_dp: directed scenarios plus random traffic against a
// seconds-of-day reference model; a monitor compares every output cycle.
module tb_digital_clock_dp;

   localparam int RING = 60;
   localparam int SNZ  = 300;
`ifdef DIGITAL_CLOCK_SNOOZE_EN
   localparam bit SNOOZE_ON = 1'b1;
`else
   localparam bit SNOOZE_ON = 1'b0;
`endif
   localparam int M_IDLE    = 0;
   localparam int M_ARMED   = 1;
   localparam int M_RINGING = 2;
   localparam int M_SNOOZE  = 3;
   localparam int DAY       = 86400;

   logic       clk;
   logic       reset;
   logic [5:0] data_in;
   logic       ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec;
   logic       on, tick, alarm_stop, snooze;
   logic [4:0] hr;
   logic [5:0] min, sec;
   logic       alarm, armed, load_err;

   digital_clock_dp #(.ALARM_RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .ld_hr        (ld_hr),
      .ld_min       (ld_min),
      .ld_sec       (ld_sec),
      .ld_alarm_hr  (ld_alarm_hr),
      .ld_alarm_min (ld_alarm_min),
      .ld_alarm_sec (ld_alarm_sec),
      .on           (on),
      .tick         (tick),
      .alarm_stop   (alarm_stop),
      .snooze       (snooze),
      .hr           (hr),
      .min          (min),
      .sec          (sec),
      .alarm        (alarm),
      .armed        (armed),
      .load_err     (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: time as seconds of day, alarm as seconds of day.
   int          m_t, m_ah, m_am, m_as, m_mode, m_cnt;
   bit [2:0]    m_v;
   bit          m_adv_prev, m_err;
   logic [19:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic model_step();
      int h, m, s, nmode, ncnt, d;
      bit aload_ok;
      if (!reset) begin
         m_t = 0; m_ah = 0; m_am = 0; m_as = 0; m_v = '0;
         m_mode = M_IDLE; m_cnt = 0; m_adv_prev = 0; m_err = 0;
      end else begin
         d = int'(data_in);
         aload_ok = (ld_alarm_hr && d <= 23) || (ld_alarm_min && d <= 59) ||
                    (ld_alarm_sec && d <= 59);
         nmode = m_mode;
         ncnt  = m_cnt;
         case (m_mode)
            M_IDLE:  if (m_v == 3'b111) nmode = M_ARMED;
            M_ARMED: if (m_adv_prev && m_t == m_ah * 3600 + m_am * 60 + m_as) nmode = M_RINGING;
            M_RINGING: begin
               if (!on || aload_ok || alarm_stop) nmode = M_ARMED;
               else if (SNOOZE_ON && snooze) nmode = M_SNOOZE;
               else if (tick) begin
                  ncnt = ncnt + 1;
                  if (ncnt == RING) nmode = M_ARMED;
               end
            end
            default: begin
               if (!on || aload_ok || alarm_stop) nmode = M_ARMED;
               else if (tick) begin
                  ncnt = ncnt + 1;
                  if (ncnt == SNZ) nmode = M_RINGING;
               end
            end
         endcase
         if (nmode != m_mode) ncnt = 0;
         h = m_t / 3600;
         m = (m_t / 60) % 60;
         s = m_t % 60;
         m_err = 0;
         if (ld_hr) begin if (d <= 23) h = d; else m_err = 1; end
         if (ld_min) begin if (d <= 59) m = d; else m_err = 1; end
         if (ld_sec) begin if (d <= 59) s = d; else m_err = 1; end
         if (ld_alarm_hr) begin if (d <= 23) begin m_ah = d; m_v[2] = 1; end else m_err = 1; end
         if (ld_alarm_min) begin if (d <= 59) begin m_am = d; m_v[1] = 1; end else m_err = 1; end
         if (ld_alarm_sec) begin if (d <= 59) begin m_as = d; m_v[0] = 1; end else m_err = 1; end
         m_adv_prev = on && tick && !(ld_hr || ld_min || ld_sec);
         if (m_adv_prev) m_t = (m_t + 1) % DAY;
         else m_t = h * 3600 + m * 60 + s;
         m_mode = nmode;
         m_cnt  = ncnt;
      end
      exp_q.push_back({5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60),
                       m_mode == M_RINGING, m_v == 3'b111, m_err});
   endtask

   // One clock: model the edge for the inputs now on the pins, then release pulses.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #2;
      ld_hr = 0; ld_min = 0; ld_sec = 0;
      ld_alarm_hr = 0; ld_alarm_min = 0; ld_alarm_sec = 0;
      tick = 0; alarm_stop = 0; snooze = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick = 1;
         cycle();
         cycle();
      end
   endtask

   task automatic load_time(input int h, input int m, input int s);
      data_in = 6'(h); ld_hr = 1; cycle();
      data_in = 6'(m); ld_min = 1; cycle();
      data_in = 6'(s); ld_sec = 1; cycle();
   endtask

   task automatic load_alarm(input int h, input int m, input int s);
      data_in = 6'(h); ld_alarm_hr = 1; cycle();
      data_in = 6'(m); ld_alarm_min = 1; cycle();
      data_in = 6'(s); ld_alarm_sec = 1; cycle();
   endtask

   // Time one second before the 00:00:05 alarm, then tick into it.
   task automatic start_ring();
      load_time(0, 0, 4);
      ticks(1);
      idle(2);
   endtask

   initial begin : monitor
      logic [19:0] got, exp;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {hr, min, sec, alarm, armed, load_err};
            n_checks++;
            if (got !== exp) begin
               n_errors++;
               $display("FAIL outputs @%0t: got %0d:%0d:%0d alarm=%b armed=%b load_err=%b, expected %0d:%0d:%0d alarm=%b armed=%b load_err=%b",
                        $time, got[19:15], got[14:9], got[8:3], got[2], got[1], got[0],
                        exp[19:15], exp[14:9], exp[8:3], exp[2], exp[1], exp[0]);
            end
         end
      end
   end

   initial begin : driver
      int a, t, k;
      reset = 0; data_in = '0; on = 0;
      ld_hr = 0; ld_min = 0; ld_sec = 0;
      ld_alarm_hr = 0; ld_alarm_min = 0; ld_alarm_sec = 0;
      tick = 0; alarm_stop = 0; snooze = 0;
      @(posedge clk);
      #2;
      // Reset with loads and a tick pending: reset must win.
      on = 1; tick = 1; data_in = 6'd7; ld_hr = 1; ld_alarm_sec = 1;
      cycle();
      idle(1);
      reset = 1;
      on = 0;
      load_time(12, 34, 56);
      idle(1);
      on = 1;
      load_time(23, 59, 59);
      ticks(1);
      data_in = 6'd60; ld_min = 1; cycle();
      idle(2);
      data_in = 6'd24; ld_hr = 1; ld_min = 1; cycle();
      idle(1);
      // Alarm at 00:00:05, ring for the full timeout.
      load_alarm(0, 0, 5);
      start_ring();
      ticks(RING);
      idle(3);
      // Stop and snooze together: stop wins, no re-ring.
      start_ring();
      alarm_stop = 1; snooze = 1; cycle();
      ticks(20);
      // Snooze then wait out the snooze delay.
      start_ring();
      snooze = 1; cycle();
      ticks(SNZ);
      idle(2);
      alarm_stop = 1; cycle();
      idle(2);
      // Alarm-field reload while ringing returns to armed.
      start_ring();
      data_in = 6'd5; ld_alarm_sec = 1; cycle();
      idle(2);
      // on=0 while ringing.
      start_ring();
      on = 0; cycle();
      idle(2);
      on = 1;
      // Reset mid-ring.
      start_ring();
      reset = 0; cycle();
      reset = 1;
      idle(2);
      // Random traffic around randomly placed alarms.
      for (int ep = 0; ep < 40; ep++) begin
         a = int'($urandom_range(0, DAY - 1));
         k = int'($urandom_range(1, 4));
         t = (a + DAY - k) % DAY;
         on = 1;
         load_alarm(a / 3600, (a / 60) % 60, a % 60);
         load_time(t / 3600, (t / 60) % 60, t % 60);
         for (int j = 0; j < 60; j++) begin
            on           = ($urandom_range(0, 39) != 0);
            tick         = ($urandom_range(0, 1) == 1);
            alarm_stop   = ($urandom_range(0, 29) == 0);
            snooze       = ($urandom_range(0, 19) == 0);
            ld_hr        = ($urandom_range(0, 49) == 0);
            ld_min       = ($urandom_range(0, 49) == 0);
            ld_sec       = ($urandom_range(0, 49) == 0);
            ld_alarm_hr  = ($urandom_range(0, 59) == 0);
            ld_alarm_min = ($urandom_range(0, 59) == 0);
            ld_alarm_sec = ($urandom_range(0, 59) == 0);
            data_in      = 6'($urandom_range(0, 63));
            cycle();
         end
      end
      idle(2);
      @(posedge clk);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/digital_clock_dp.md
DIGITAL_CLOCK_DP -- requirements
Module: digital_clock_dp

Interface
REQ-001 SHALL have parameter ALARM_RING_SECS, default 60: ticks the alarm rings before it self-clears.
REQ-002 SHALL have parameter SNOOZE_SECS, default 300: ticks of snooze delay, used only with DIGITAL_CLOCK_SNOOZE_EN.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port data_in, input, 6 bits: shared load bus, carrying an hour, minute or second value.
REQ-006 SHALL have ports ld_hr, ld_min and ld_sec, input, 1 bit each: load strobes for the time registers.
REQ-007 SHALL have ports ld_alarm_hr, ld_alarm_min and ld_alarm_sec, input, 1 bit each: load strobes for the alarm registers.
REQ-008 SHALL have port on, input, 1 bit: clock-run enable.
REQ-009 SHALL have port tick, input, 1 bit: one-cycle 1 Hz enable pulse.
REQ-010 SHALL have port alarm_stop, input, 1 bit: pulse that silences a ringing alarm.
REQ-011 SHALL have port snooze, input, 1 bit: snooze request pulse (macro-gated).
REQ-012 SHALL have outputs hr (5 bits), min (6 bits) and sec (6 bits): current time.
REQ-013 SHALL have output alarm, 1 bit: ringing indicator.
REQ-014 SHALL have output armed, 1 bit: all three alarm fields are valid.
REQ-015 SHALL have output load_err, 1 bit: one-cycle pulse on a rejected load.

Function
REQ-016 Load strobe high SHALL capture data_in into the selected register at that clock edge; the new value is visible the next cycle.
REQ-017 Loaded value out of range (hour >23, minute or second >59) SHALL leave the register unchanged and pulse load_err for one cycle.
REQ-018 Several strobes high together SHALL each load the same data_in value, with an independent range check per field.
REQ-019 Time counting SHALL advance only when on=1, tick=1 and no time-load strobe is high; any time-load in the cycle suppresses that tick entirely.
REQ-020 Time SHALL advance as follows: sec increments; sec 59->0 carries into min; min 59->0 carries into hr; hr 23->0 (23:59:59 -> 00:00:00 in one tick).
REQ-021 on=0 SHALL freeze the time registers; loads still apply.
REQ-022 A valid-bit per alarm field SHALL be set on a successful load; armed = AND of the three valid-bits.
REQ-023 Alarm FSM SHALL have states IDLE, ARMED, RINGING and SNOOZE.
REQ-024 FSM SHALL go IDLE->ARMED when armed becomes 1.
REQ-025 FSM SHALL go ARMED->RINGING on the cycle after a tick advance whose new time equals the alarm time; time loads never trigger the alarm.
REQ-026 FSM SHALL go RINGING->ARMED on alarm_stop, or after ALARM_RING_SECS ticks counted from entry.
REQ-027 FSM SHALL go RINGING->SNOOZE on snooze with no alarm_stop; when both are high together, alarm_stop wins.
REQ-028 FSM SHALL go SNOOZE->RINGING after SNOOZE_SECS ticks, and SNOOZE->ARMED on alarm_stop.
REQ-029 Any successful alarm-field load in RINGING or SNOOZE SHALL return the FSM to ARMED.
REQ-030 on=0 SHALL force RINGING or SNOOZE to ARMED.
REQ-031 alarm SHALL be 1 exactly while the FSM is in RINGING, as a registered output.
REQ-032 Ring and snooze counters SHALL be 9 bits wide and clear on every state entry.

Reset
REQ-033 reset=0 at a clock edge SHALL force hr, min, sec and the alarm registers to 0, valid-bits to 0, FSM to IDLE, and alarm, armed and load_err to 0.
REQ-034 Reset SHALL take priority over loads and ticks in the same cycle; reset mid-ring drops alarm the next cycle.

Configuration
REQ-035 Macro DIGITAL_CLOCK_SNOOZE_EN defined SHALL include the SNOOZE state, the snooze counter and snooze input handling.
REQ-036 Without DIGITAL_CLOCK_SNOOZE_EN, the snooze port SHALL remain on the interface but be ignored; RINGING leaves only via alarm_stop, timeout, alarm-field load or on=0.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding and the constants HR_MAX=23, MIN_MAX=59 and SEC_MAX=59.
REQ-038 Sub-module digital_clock_counter (parameterised modulo-N counter with load, range check, enable and carry-out) SHALL be instantiated three times for sec, min and hr.

Verification
REQ-039 Scenario: reset=0, then ld_hr with data_in=12, ld_min with 34, ld_sec with 56 on consecutive cycles -> hr:min:sec reads 12:34:56, load_err=0.
REQ-040 Scenario: load 23:59:59, on=1, one tick -> 00:00:00 on the next cycle.
REQ-041 Scenario: ld_min with data_in=60 -> min unchanged, load_err=1 for exactly one cycle.
REQ-042 Scenario: alarm loaded as 00:00:05, time 00:00:04, on=1, one tick -> alarm=1 one cycle after sec becomes 5; 60 more ticks -> alarm=0, FSM back in ARMED.
REQ-043 Scenario: alarm ringing, alarm_stop and snooze asserted in the same cycle -> alarm=0, FSM in ARMED with no later re-ring.
REQ-044 Scenario: with the macro defined and the alarm ringing, a snooze pulse followed by 300 ticks -> alarm=1 again; without the macro, the snooze pulse leaves alarm=1.
